alu_mul_seq: RTL

- Multi-cycle sequencer that computes an 8x8 multiply (low 8 bits of the product) using shift-and-add on the shared 8-bit combinational ALU.
- It drives the ALU operands and opcode through the datapath's ALU input mux while it owns the ALU (AluReq high).
- Sits beside the ALU in the basic processor. It is launched by a Start/Done handshake from the control unit.

---
 rtl/alu_mul_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Purpose  : 8x8 shift-and-add multiplier (low byte of the product) that
//            borrows the shared combinational ALU for every arithmetic step.
// Option   : define ALU_MUL_SEQ_EARLY_TERM_EN to finish as soon as the
//            shifted multiplier reaches zero.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
  parameter int              W      = 8,
  parameter int              OPW    = 3,
  parameter logic [OPW-1:0]  OP_ADD = 3'b000,
  parameter logic [OPW-1:0]  OP_LSH = 3'b001,
  parameter logic [OPW-1:0]  OP_RSH = 3'b010
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [W-1:0]   MulA,
  input  logic [W-1:0]   MulB,
  input  logic [W-1:0]   AluOut,
  input  logic           AluZero,
  output logic [W-1:0]   AluA,
  output logic [W-1:0]   AluB,
  output logic [OPW-1:0] AluOp,
  output logic           AluReq,
  output logic           Busy,
  output logic           Done,
  output logic [W-1:0]   Product
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         state;
  logic [W-1:0]   acc;
  logic [W-1:0]   mc;
  logic [W-1:0]   mr;
  logic [2:0]     cnt;
  logic           last_iter;

`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
  // AluZero reflects the multiplier just shifted in SHR: no set bits remain.
  assign last_iter = (cnt == 3'd7) || AluZero;
`else
  logic unused_zero;
  assign unused_zero = AluZero;
  assign last_iter   = (cnt == 3'd7);
`endif

  // ALU drive values are registered for the state being entered, so every
  // output is a pure register with no path from Start.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      acc     <= '0;
      mc      <= '0;
      mr      <= '0;
      cnt     <= '0;
      Product <= '0;
      Done    <= 1'b0;
      Busy    <= 1'b0;
      AluReq  <= 1'b0;
      AluA    <= '0;
      AluB    <= '0;
      AluOp   <= OP_ADD;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            acc    <= '0;
            mc     <= MulA;
            mr     <= MulB;
            cnt    <= '0;
            state  <= S_ADD;
            Busy   <= 1'b1;
            AluReq <= 1'b1;
            AluOp  <= OP_ADD;
            AluA   <= '0;
            AluB   <= MulA;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ADD: begin
          if (mr[0]) acc <= AluOut;
          state <= S_SHL;
          AluOp <= OP_LSH;
          AluA  <= mc;
          AluB  <= '0;
        end
        S_SHL: begin
          mc    <= AluOut;
          state <= S_SHR;
          AluOp <= OP_RSH;
          AluA  <= mr;
          AluB  <= '0;
        end
        S_SHR: begin
          mr <= AluOut;
          if (last_iter) begin
            Product <= acc;
            state   <= S_DONE;
            Done    <= 1'b1;
            Busy    <= 1'b0;
            AluReq  <= 1'b0;
            AluOp   <= OP_ADD;
            AluA    <= '0;
            AluB    <= '0;
          end else begin
            cnt   <= cnt + 3'd1;
            state <= S_ADD;
            AluOp <= OP_ADD;
            AluA  <= acc;
            AluB  <= mc;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
